// File: rtl/anim_sprite_ctrl_pkg.sv
// Shared types and helpers for the sprite animator: FSM states, colour bit
// positions and the column pattern generator.
package anim_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int COLOR_R  = 1;
  localparam int COLOR_G  = 0;
  localparam int MAX_COLS = 64;

  // SPRITE_W ones; pos 0 sits in the MSBs and each pos step moves right by sw.
  function automatic logic [MAX_COLS-1:0] sprite_pattern(input int pos, input int cols = 8,
                                                          input int sw = 2);
    logic [MAX_COLS-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_COLS; i++)
      if (i >= cols - sw*(pos+1) && i < cols - sw*pos) p[i] = 1'b1;
    return p;
  endfunction
endpackage

// File: rtl/anim_sprite_ctrl_if.sv
// Request/display bundle between button logic, animator and matrix pins.
interface anim_sprite_ctrl_if #(
  parameter int NCH  = 3,
  parameter int COLS = 8,
  parameter int ROWS = 8
);
  logic [NCH-1:0]  req;
  logic            off;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] r;
  logic [COLS-1:0] g;
  logic            busy;
  logic [NCH-1:0]  done;

  modport master (output req, off, input row, r, g, busy, done);
  modport slave  (input req, off, output row, r, g, busy, done);
endinterface

// File: rtl/anim_sprite_ctrl_row_scan.sv
// Row scanner: cycles rows, maps each row to its channel band and drives the
// registered row/colour pins from that channel's sprite position.
module anim_row_scan
  import anim_pkg::*;
#(
  parameter int NCH         = 3,
  parameter int COLS        = 8,
  parameter int ROWS        = 8,
  parameter int SPRITE_W    = 2,
  parameter int ROWS_PER_CH = 2,
  parameter int PW          = 2,
  parameter logic [2*NCH-1:0] CH_COLOR = 6'b11_01_10
) (
  input  logic                clk1khz,
  input  logic                rst,
  input  logic [NCH*PW-1:0]   pos_flat,
  input  logic                off,
  output logic [ROWS-1:0]     row,
  output logic [COLS-1:0]     r,
  output logic [COLS-1:0]     g
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [RW-1:0]               cnt;
  logic [NCH-1:0]              inband;
  logic [NCH-1:0][COLS-1:0]    pat;
  logic [COLS-1:0]             r_nxt, g_nxt;

  for (genvar c = 0; c < NCH; c++) begin : g_band
    localparam int BASE = c*(ROWS_PER_CH+1);
    assign inband[c] = (int'(cnt) >= BASE) && (int'(cnt) < BASE + ROWS_PER_CH);
    assign pat[c]    = COLS'(sprite_pattern(int'(pos_flat[c*PW +: PW]), COLS, SPRITE_W));
  end

  // Bands are disjoint, so at most one channel claims the current row.
  always_comb begin
    r_nxt = '0;
    g_nxt = '0;
    for (int i = 0; i < NCH; i++)
      if (inband[i]) begin
        if (CH_COLOR[2*i+COLOR_R]) r_nxt = pat[i];
        if (CH_COLOR[2*i+COLOR_G]) g_nxt = pat[i];
      end
  end

  always_ff @(posedge clk1khz or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      row <= '1;
      r   <= '0;
      g   <= '0;
    end else begin
      cnt <= (cnt == RW'(ROWS-1)) ? '0 : cnt + 1'b1;
      row <= off ? '1 : ~(ROWS'(1) << cnt);
      r   <= off ? '0 : r_nxt;
      g   <= off ? '0 : g_nxt;
    end
  end
endmodule

// File: rtl/anim_sprite_ctrl.sv
// Multi-channel sprite animator with round-robin play arbitration.
// Define ANIM_QUEUE_EN to queue requests that arrive while a play is running.
module anim_sprite_ctrl
  import anim_pkg::*;
#(
  parameter int NCH         = 3,
  parameter int COLS        = 8,
  parameter int ROWS        = 8,
  parameter int SPRITE_W    = 2,
  parameter int ROWS_PER_CH = 2,
  parameter int STEP_DIV    = 1000,
  parameter logic [2*NCH-1:0] CH_COLOR = {2'b11, 2'b01, 2'b10}
) (
  input  logic               clk1khz,
  input  logic               rst,
  anim_sprite_ctrl_if.slave  bus
);
  localparam int NPOS = COLS / SPRITE_W;
  localparam int PW   = (NPOS > 1) ? $clog2(NPOS) : 1;
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW   = $clog2(STEP_DIV);

  state_t                  state, state_nxt;
  logic [NCH-1:0]          req_q, req_q2, edg, acc, pend, clr;
  logic [NCH-1:0][PW-1:0]  pos;
  logic [NCH-1:0]          dir;
  logic [CW-1:0]           act, last, sel;
  logic                    sel_ok, tc, at_end;
  logic [TW-1:0]           tick;
  logic [NCH*PW-1:0]       pos_flat;

  assign edg = bus.off ? '0 : (req_q & ~req_q2);

`ifdef ANIM_QUEUE_EN
  assign acc = edg;
`else
  // Single-slot mode: only an idle, empty arbiter takes a request, lowest index first.
  always_comb begin
    acc = '0;
    if (state == IDLE && pend == '0)
      for (int i = NCH-1; i >= 0; i--)
        if (edg[i]) begin
          acc    = '0;
          acc[i] = 1'b1;
        end
  end
`endif

  always_comb begin
    sel_ok = 1'b0;
    sel    = last;
    for (int i = 1; i <= NCH; i++)
      if (!sel_ok && pend[(int'(last)+i) % NCH]) begin
        sel_ok = 1'b1;
        sel    = CW'((int'(last)+i) % NCH);
      end
  end

  assign tc     = (tick == TW'(STEP_DIV-1));
  assign at_end = dir[act] ? (pos[act] == '0) : (pos[act] == PW'(NPOS-1));
  assign clr    = (state == DONE) ? (NCH'(1) << act) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_ok) state_nxt = RUN;
      RUN:     if (tc && at_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1khz or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk1khz or negedge rst) begin
    if (!rst) begin
      req_q  <= '0;
      req_q2 <= '0;
      pend   <= '0;
      pos    <= '0;
      dir    <= '0;
      act    <= '0;
      last   <= CW'(NCH-1);
      tick   <= '0;
    end else begin
      req_q  <= bus.req;
      req_q2 <= req_q;
      // A fresh edge on act in its DONE cycle re-arms pend.
      pend   <= (pend & ~clr) | acc;
      case (state)
        IDLE: if (sel_ok) begin
          act  <= sel;
          tick <= '0;
        end
        RUN: begin
          tick <= tc ? '0 : tick + 1'b1;
          if (tc && !at_end) pos[act] <= dir[act] ? pos[act] - 1'b1 : pos[act] + 1'b1;
        end
        DONE: begin
          dir[act] <= ~dir[act];
          last     <= act;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = clr;
  assign pos_flat = pos;

  anim_row_scan #(
    .NCH(NCH), .COLS(COLS), .ROWS(ROWS), .SPRITE_W(SPRITE_W),
    .ROWS_PER_CH(ROWS_PER_CH), .PW(PW), .CH_COLOR(CH_COLOR)
  ) u_scan (
    .clk1khz (clk1khz),
    .rst     (rst),
    .pos_flat(pos_flat),
    .off     (bus.off),
    .row     (bus.row),
    .r       (bus.r),
    .g       (bus.g)
  );
endmodule

// File: tb/tb_anim_sprite_ctrl.sv
// Scoreboard bench for anim_sprite_ctrl: stimulus queues expected done pulses,
// a monitor pops and checks them; display state is checked between plays.
module tb_anim_sprite_ctrl;
  localparam int NCH = 3, COLS = 8, ROWS = 8, SD = 4;

  logic clk1khz = 1'b0;
  logic rst     = 1'b0;
  always #5 clk1khz = ~clk1khz;

  anim_sprite_ctrl_if #(.NCH(NCH), .COLS(COLS), .ROWS(ROWS)) bus ();

  anim_sprite_ctrl #(
    .NCH(NCH), .COLS(COLS), .ROWS(ROWS), .SPRITE_W(2), .ROWS_PER_CH(2),
    .STEP_DIV(SD), .CH_COLOR(6'b11_01_10)
  ) dut (
    .clk1khz(clk1khz),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct { int ch; int cyc; } exp_t;
  exp_t sbq[$];
  exp_t e;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  int a;

  always @(posedge clk1khz) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Monitor: every done pulse must match the next queued expectation.
  always @(negedge clk1khz) begin
    if (rst && bus.done !== '0) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL done_unexpected: got %b at cycle %0d expected none", bus.done, cyc);
      end else begin
        e = sbq.pop_front();
        chk("done_ch", 32'(bus.done), 32'(1) << e.ch);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk1khz);
  endtask

  task automatic start(input logic [NCH-1:0] m, output int t0);
    t0 = cyc;
    bus.req = m;
    cyc_wait(3);
    bus.req = '0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sbq.size() != 0 && k < budget) begin
      @(negedge clk1khz);
      k++;
    end
    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending done pulses expected 0", sbq.size());
      sbq.delete();
    end
    cyc_wait(2);
  endtask

  task automatic row_chk(input string nm, input int k, input logic [7:0] er, input logic [7:0] eg);
    logic [7:0] want;
    bit found = 0;
    want = ~(8'h01 << k);
    for (int i = 0; i < 2*ROWS && !found; i++) begin
      @(negedge clk1khz);
      if (bus.row === want) begin
        found = 1;
        chk(nm, {16'h0, bus.r, bus.g}, {16'h0, er, eg});
      end
    end
    if (!found) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got no row %0d select expected row %h", nm, k, want);
    end
  endtask

  initial begin
    bus.req = '0;
    bus.off = 1'b0;
    cyc_wait(2);
    chk("rst_row",  32'(bus.row),  32'hFF);
    chk("rst_r",    32'(bus.r),    32'h00);
    chk("rst_g",    32'(bus.g),    32'h00);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    rst = 1'b1;
    cyc_wait(2);
    row_chk("init_ch0",  0, 8'hC0, 8'h00);
    row_chk("init_ch1",  3, 8'h00, 8'hC0);
    row_chk("init_ch2",  7, 8'hC0, 8'hC0);
    row_chk("gap_row2",  2, 8'h00, 8'h00);

    // ch0 plays right: edge->pend 2 cycles, pend->busy 1, play 3*SD+SD+1
    a = cyc;
    sbq.push_back('{0, a + 19});
    bus.req = 3'b001;
    cyc_wait(2);
    chk("busy_pre", 32'(bus.busy), 32'h0);
    cyc_wait(1);
    chk("busy_run", 32'(bus.busy), 32'h1);
    bus.req = '0;
    drain(60);
    chk("busy_idle", 32'(bus.busy), 32'h0);
    row_chk("ch0_right", 1, 8'h03, 8'h00);

    // second play reverses
    start(3'b001, a);
    sbq.push_back('{0, a + 19});
    drain(60);
    row_chk("ch0_left", 0, 8'hC0, 8'h00);

    // simultaneous ch1+ch2 edges
    start(3'b110, a);
    sbq.push_back('{1, a + 19});
`ifdef ANIM_QUEUE_EN
    sbq.push_back('{2, a + 37});
`endif
    drain(100);
    row_chk("ch1_played", 4, 8'h00, 8'h03);
`ifdef ANIM_QUEUE_EN
    row_chk("ch2_played", 6, 8'h03, 8'h03);
`else
    row_chk("ch2_dropped", 6, 8'hC0, 8'hC0);
`endif

    // req[1] arriving during ch0's play
    start(3'b001, a);
    sbq.push_back('{0, a + 19});
    cyc_wait(5);
    bus.req = 3'b010;
    cyc_wait(3);
    bus.req = '0;
`ifdef ANIM_QUEUE_EN
    sbq.push_back('{1, a + 37});
`endif
    drain(100);
    chk("busy_after_busyreq", 32'(bus.busy), 32'h0);
`ifdef ANIM_QUEUE_EN
    row_chk("ch1_queued", 3, 8'h00, 8'hC0);
`else
    row_chk("ch1_unmoved", 3, 8'h00, 8'h03);
`endif

    // blank display during a ch2 play
    start(3'b100, a);
    sbq.push_back('{2, a + 19});
    bus.off = 1'b1;
    cyc_wait(2);
    begin
      int bad = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk1khz);
        if (bus.row !== 8'hFF || bus.r !== 8'h00 || bus.g !== 8'h00) bad++;
      end
      chk("off_blank_bad_samples", bad, 0);
    end
    drain(60);
    bus.off = 1'b0;
`ifdef ANIM_QUEUE_EN
    row_chk("ch2_after_off", 6, 8'hC0, 8'hC0);
`else
    row_chk("ch2_after_off", 6, 8'h03, 8'h03);
`endif

    // reset in the middle of a play, just after step 2
    start(3'b001, a);
    cyc_wait(9);
    rst = 1'b0;
    #1;
    chk("midrst_row",  32'(bus.row),  32'hFF);
    chk("midrst_rg",   {16'h0, bus.r, bus.g}, 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_done", 32'(bus.done), 32'h0);
    cyc_wait(3);
    rst = 1'b1;
    cyc_wait(2);
    row_chk("postrst_ch0", 0, 8'hC0, 8'h00);
    row_chk("postrst_ch1", 3, 8'h00, 8'hC0);
    row_chk("postrst_ch2", 6, 8'hC0, 8'hC0);
    start(3'b001, a);
    sbq.push_back('{0, a + 19});
    drain(60);
    row_chk("postrst_play", 1, 8'h03, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/anim_sprite_ctrl.md
# anim_sprite_ctrl

Parametrised multi-channel sprite animator and bicolour dot-matrix scan driver. Each of NCH channels owns a horizontal band of rows and a SPRITE_W-wide sprite that slides across the matrix in one direction per play, reversing direction on the next play. One channel animates at a time under round-robin arbitration. Position and channel change in the same cycle, so no wrong-channel frame is ever displayed. The block replaces the fixed three-animal animator and sits between the request-button logic and the matrix pins.

## Interface
- NCH, 3: number of sprite channels (1..4)
- COLS, 8: matrix columns, equal to the r/g width
- ROWS, 8: matrix rows, equal to the row width
- SPRITE_W, 2: sprite width in columns; COLS % SPRITE_W == 0
- ROWS_PER_CH, 2: rows per channel band; NCH*(ROWS_PER_CH+1)-1 <= ROWS
- STEP_DIV, 1000: clk1khz cycles per animation step (>= 2)
- CH_COLOR, {2'b11,2'b01,2'b10}: 2 bits per channel, indexed from the LSB; bit1 = red, bit0 = green
- clk1khz  in  1  system and scan clock
- rst  in  1  asynchronous, active-low reset
- req  in  NCH  per-channel play request; only rising edges count
- off  in  1  display blank, synchronous
- row  out  ROWS  row select, active-low one-hot
- r  out  COLS  red column drive, active-high
- g  out  COLS  green column drive, active-high
- busy  out  1  a play is in progress
- done  out  NCH  one-cycle pulse when a channel's play completes

## Operation
- NPOS = COLS/SPRITE_W.
- Each channel c holds:
  - pos[c] in 0..NPOS-1
  - dir[c], where 0 = next play moves right and 1 = next play moves left
  - pend[c]
- Column pattern = SPRITE_W ones, left-shifted so that pos 0 occupies the MSBs [COLS-1 : COLS-SPRITE_W]. Each pos step moves the sprite SPRITE_W columns right.
- Request capture: req is registered once, then edge-detected. An edge sets pend[c]. Edges are ignored while off=1.
- FSM, states IDLE, RUN, DONE:
  - IDLE: if any pend bit is set, select the first set bit searching upward from last+1 (wrap-around). Load act=c, clear tick, set busy, go to RUN.
  - RUN: tick counts 0..STEP_DIV-1. At terminal count:
    - if pos[act] is at the travel end (NPOS-1 when dir=0, 0 when dir=1), go to DONE;
    - otherwise pos[act] moves one step (+1 when dir=0, -1 when dir=1).
  - DONE: toggle dir[act], clear pend[act], pulse done[act], set last=act, clear busy, go to IDLE.
- Same-cycle events:
  - A new edge on act in the DONE cycle wins: pend stays 1.
  - Edges on multiple channels in one cycle all latch.
- Scan: the scan counter wraps 0..ROWS-1 every cycle.
  - Row k belongs to channel c when k - c*(ROWS_PER_CH+1) is in 0..ROWS_PER_CH-1. All other rows are blank.
  - r = pattern(pos[c]) when CH_COLOR[c][1], else 0. g uses CH_COLOR[c][0] the same way.
- off=1: row = all ones and r = g = 0 from the next cycle. The animation FSM keeps running.

## Timing
- Reset values:
  - row = all ones; r = g = 0; busy = 0; done = 0
  - all pos = 0, dir = 0, pend = 0; state IDLE; last = NCH-1, so ch0 is served first
- req rising edge to pend set: 2 cycles. pend to busy high: 1 cycle.
- Each step lands exactly STEP_DIV cycles after the previous step or after the RUN entry.
- A full play lasts (NPOS-1)*STEP_DIV cycles to the final step, plus STEP_DIV cycles to DONE, plus 1 DONE cycle.
- Scan outputs are registered: counter value k appears on the pins 1 cycle later, with row and column data coherent.
- Reset asserted mid-play: everything returns to its reset value immediately. No done pulse is issued.

## Configuration
- ANIM_QUEUE_EN defined:
  - Edges arriving while busy, including edges for act, latch into pend and are served after DONE.
- ANIM_QUEUE_EN undefined:
  - Edges are accepted only while the FSM is in IDLE and no pend bit is set. All other edges are dropped.
  - At most one pend bit is ever set; on a simultaneous multi-edge, only the lowest index latches.

## Structure
- Package anim_pkg holds:
  - the state enum (IDLE/RUN/DONE)
  - the colour bit indices (COLOR_R=1, COLOR_G=0)
  - function sprite_pattern(pos), which returns the COLS-bit column pattern
- Sub-module anim_row_scan: scan counter, row decode, band lookup, colour masking and output registers. It takes flattened pos vectors and off as inputs.
- The arbiter, FSM and tick counter stay in the top module.

## Test plan
- Reset, then pulse req[0], with STEP_DIV=4 → pos[0] steps 0→1→2→3 at 4-cycle intervals; done[0] pulses; dir[0]=1; rows 0–1 show r moving 8'b11000000 → 8'b00000011 with g=0.
- Pulse req[0] a second time → the sprite moves 3→0 and dir[0] returns to 0.
- req[1] and req[2] rise in the same cycle → ch1 plays fully, then ch2; ch2 appears on rows 6–7 with r=g set (yellow); done[1] precedes done[2].
- With ANIM_QUEUE_EN, req[1] during ch0's play → ch1 runs directly after ch0's DONE. Without the macro → the req[1] edge is dropped and busy falls after ch0.
- Hold off=1 during a play → row = 8'hFF and r = g = 0; done still pulses on schedule; after off is released, the final pos is displayed.
- Assert rst low at step 2 → all outputs return to reset values at once, with no done pulse; a subsequent req[0] starts from pos 0 moving right.
